// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/write-back/immediate enums,
// the ID/EX register layout and the immediate builder.
package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // All-zero value of this struct is the pipeline bubble.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        wb_sel_e     wb_sel;
    } id_ex_t;

    // Takes inst[31:7]; the opcode bits never contribute to an immediate.
    function automatic logic [31:0] gen_imm(input logic [31:7] ins, input imm_fmt_e fmt);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'h000};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // alt is inst[30]; it only selects SUB for register-register ops.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt, input logic is_op);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 integer register file: two combinational read ports with write-back
// bypass, one write port, x0 hard-wired to zero.
module register_file (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);

    logic [31:0] w_regs [32];
    logic        w_byp_a;
    logic        w_byp_b;

    assign w_regs[0] = '0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0] r_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (clk_en && i_we && (i_waddr == 5'(gi))) begin
                    r_q <= i_wdata;
                end
            end
            assign w_regs[gi] = r_q;
        end
    endgenerate

    // A write landing this cycle is visible to decode before it reaches the array.
    assign w_byp_a   = i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr_a);
    assign w_byp_b   = i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr_b);
    assign o_rdata_a = w_byp_a ? i_wdata : w_regs[i_raddr_a];
    assign o_rdata_b = w_byp_b ? i_wdata : w_regs[i_raddr_b];

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: combinational decode, register read, load-use hazard
// detection and the ID/EX pipeline register.
module instruction_decode #(
    parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [31:0] i_if_inst,
    input  logic [31:0] i_if_pc,
    input  logic        i_flush,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_rd_addr,
    input  logic [31:0] i_wb_data,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_rd_addr,
    output logic        o_stall,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_rs1_data,
    output logic [31:0] o_id_rs2_data,
    output logic [31:0] o_id_imm,
    output logic [4:0]  o_id_rs1_addr,
    output logic [4:0]  o_id_rs2_addr,
    output logic [4:0]  o_id_rd_addr,
    output logic [2:0]  o_id_funct3,
    output logic [3:0]  o_id_alu_op,
    output logic        o_id_alu_src_a,
    output logic        o_id_alu_src_b,
    output logic        o_id_mem_read,
    output logic        o_id_mem_write,
    output logic        o_id_reg_write,
    output logic        o_id_branch,
    output logic        o_id_jump,
    output logic        o_id_illegal,
    output logic [1:0]  o_id_wb_sel
);

    import riscv_pkg::*;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    imm_fmt_e    w_fmt;
    alu_op_e     w_alu_op;
    wb_sel_e     w_wb_sel;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_has_rd;
    logic        w_src_a;
    logic        w_src_b;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_jump;
    logic        w_nop;
    logic        w_illegal;
    logic [4:0]  w_rs1_addr;
    logic [4:0]  w_rs2_addr;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic        w_ex_hit;
    id_ex_t      w_next;
    id_ex_t      r_id_ex;

    assign w_opcode = i_if_inst[6:0];
    assign w_funct3 = i_if_inst[14:12];
    assign w_funct7 = i_if_inst[31:25];

    always_comb begin
        w_fmt       = IMM_NONE;
        w_alu_op    = ALU_ADD;
        w_wb_sel    = WB_ALU;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_has_rd    = 1'b0;
        w_src_a     = 1'b0;
        w_src_b     = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_nop       = 1'b0;
        w_illegal   = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_fmt    = IMM_U;
                w_alu_op = ALU_PASS_B;
                w_src_b  = 1'b1;
                w_has_rd = 1'b1;
            end
            OPC_AUIPC: begin
                w_fmt    = IMM_U;
                w_src_a  = 1'b1;
                w_src_b  = 1'b1;
                w_has_rd = 1'b1;
            end
            OPC_JAL: begin
                // ALU forms the target PC+imm; the link value comes from PC+4.
                w_fmt    = IMM_J;
                w_src_a  = 1'b1;
                w_src_b  = 1'b1;
                w_jump   = 1'b1;
                w_has_rd = 1'b1;
                w_wb_sel = WB_PC4;
            end
            OPC_JALR: begin
                w_fmt     = IMM_I;
                w_use_rs1 = 1'b1;
                w_src_b   = 1'b1;
                w_jump    = 1'b1;
                w_has_rd  = 1'b1;
                w_wb_sel  = WB_PC4;
            end
            OPC_BRANCH: begin
                w_fmt     = IMM_B;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_alu_op  = ALU_SUB;
                w_branch  = 1'b1;
            end
            OPC_LOAD: begin
                w_fmt      = IMM_I;
                w_use_rs1  = 1'b1;
                w_src_b    = 1'b1;
                w_mem_read = 1'b1;
                w_has_rd   = 1'b1;
                w_wb_sel   = WB_MEM;
            end
            OPC_STORE: begin
                w_fmt       = IMM_S;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_src_b     = 1'b1;
                w_mem_write = 1'b1;
            end
            OPC_OP_IMM: begin
                w_fmt     = IMM_I;
                w_use_rs1 = 1'b1;
                w_src_b   = 1'b1;
                w_has_rd  = 1'b1;
                w_alu_op  = alu_decode(w_funct3, i_if_inst[30], 1'b0);
            end
            OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_has_rd  = 1'b1;
                w_alu_op  = alu_decode(w_funct3, i_if_inst[30], 1'b1);
                // Only SUB and SRA use the alternate funct7 encoding.
                if (!((w_funct7 == 7'h00) ||
                      ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))))) begin
                    w_illegal = 1'b1;
                end
            end
            OPC_FENCE,
            OPC_SYSTEM: begin
                w_nop = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        if (i_if_inst == NOP_INST) begin
            w_nop = 1'b1;
        end
    end

    // Unused source fields read as x0 so they can never raise a hazard.
    assign w_rs1_addr = (w_use_rs1 && !w_illegal && !w_nop) ? i_if_inst[19:15] : 5'd0;
    assign w_rs2_addr = (w_use_rs2 && !w_illegal && !w_nop) ? i_if_inst[24:20] : 5'd0;

    register_file u_register_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .i_we      (i_wb_we),
        .i_waddr   (i_wb_rd_addr),
        .i_wdata   (i_wb_data),
        .i_raddr_a (w_rs1_addr),
        .i_raddr_b (w_rs2_addr),
        .o_rdata_a (w_rs1_data),
        .o_rdata_b (w_rs2_data)
    );

    assign w_ex_hit = (i_ex_rd_addr != 5'd0) &&
                      ((w_rs1_addr == i_ex_rd_addr) || (w_rs2_addr == i_ex_rd_addr));
    assign o_stall  = !i_flush && i_ex_mem_read && w_ex_hit;

    always_comb begin
        w_next = '0;
        if (w_illegal) begin
            // Keep the PC so the trap path can report the faulting address.
            w_next.illegal = 1'b1;
            w_next.pc      = i_if_pc;
        end else if (!w_nop) begin
            w_next.pc        = i_if_pc;
            w_next.rs1_data  = w_rs1_data;
            w_next.rs2_data  = w_rs2_data;
            w_next.imm       = gen_imm(i_if_inst[31:7], w_fmt);
            w_next.rs1_addr  = w_rs1_addr;
            w_next.rs2_addr  = w_rs2_addr;
            w_next.rd_addr   = w_has_rd ? i_if_inst[11:7] : 5'd0;
            w_next.funct3    = w_funct3;
            w_next.alu_op    = w_alu_op;
            w_next.alu_src_a = w_src_a;
            w_next.alu_src_b = w_src_b;
            w_next.mem_read  = w_mem_read;
            w_next.mem_write = w_mem_write;
            w_next.reg_write = w_has_rd;
            w_next.branch    = w_branch;
            w_next.jump      = w_jump;
            w_next.wb_sel    = w_wb_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id_ex <= '0;
        end else if (clk_en) begin
            if (i_flush || o_stall) begin
                r_id_ex <= '0;
            end else begin
                r_id_ex <= w_next;
            end
        end
    end

    assign o_id_pc        = r_id_ex.pc;
    assign o_id_rs1_data  = r_id_ex.rs1_data;
    assign o_id_rs2_data  = r_id_ex.rs2_data;
    assign o_id_imm       = r_id_ex.imm;
    assign o_id_rs1_addr  = r_id_ex.rs1_addr;
    assign o_id_rs2_addr  = r_id_ex.rs2_addr;
    assign o_id_rd_addr   = r_id_ex.rd_addr;
    assign o_id_funct3    = r_id_ex.funct3;
    assign o_id_alu_op    = r_id_ex.alu_op;
    assign o_id_alu_src_a = r_id_ex.alu_src_a;
    assign o_id_alu_src_b = r_id_ex.alu_src_b;
    assign o_id_mem_read  = r_id_ex.mem_read;
    assign o_id_mem_write = r_id_ex.mem_write;
    assign o_id_reg_write = r_id_ex.reg_write;
    assign o_id_branch    = r_id_ex.branch;
    assign o_id_jump      = r_id_ex.jump;
    assign o_id_illegal   = r_id_ex.illegal;
    assign o_id_wb_sel    = r_id_ex.wb_sel;

endmodule
